// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc
// Front end of the synth voice engine. Parses a raw MIDI byte stream into
// Note On / Note Off / Poly Key Pressure, allocates a voice slot by a
// one-slot-per-cycle linear scan, and emits one-cycle event strobes with
// note, velocity, channel and slot address.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 16
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       busy,
    output logic       overrun,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic [7:0] addr
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_ON  = 2'd0,
        EV_OFF = 2'd1,
        EV_KP  = 2'd2
    } ev_t;

    // FSM
    state_t r_state;
    state_t w_next;
    logic   w_busy;

    // Parser state
    logic       r_stat_vld;
    logic [3:0] r_stat_hi;
    logic [3:0] r_stat_ch;
    logic       r_cnt;
    logic [6:0] r_key;

    // Event under search
    ev_t        r_ev_type;
    logic [6:0] r_ev_note;
    logic [6:0] r_ev_vel;
    logic [3:0] r_ev_ch;

    // Scan bookkeeping
    logic [IDX_W-1:0] r_scan_idx;
    logic             r_match_vld;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free_vld;
    logic [IDX_W-1:0] r_free_idx;
    logic [IDX_W-1:0] r_steal;

    // Voice table
    logic [NUM_VOICES-1:0] r_vvld;
    logic [6:0]            r_vnote [NUM_VOICES];
    logic [3:0]            r_vch   [NUM_VOICES];

    // Byte classification
    logic       w_realtime;
    logic       w_accept;
    logic       w_is_data;
    logic       w_is_chan;
    logic       w_is_sys;
    logic       w_one_byte;
    logic       w_complete;
    logic       w_trigger;
    ev_t        w_new_type;

    // Scan / decision
    logic             w_slot_vld;
    logic             w_hit;
    logic             w_fin_match_vld;
    logic [IDX_W-1:0] w_fin_match_idx;
    logic             w_fin_free_vld;
    logic [IDX_W-1:0] w_fin_free_idx;
    logic             w_scan_done;
    logic             w_emit_p;
    logic             w_emit_r;
    logic             w_emit_k;
    logic [IDX_W-1:0] w_emit_idx;
    logic             w_steal_adv;

    // Classify the incoming byte and detect a completed, search-worthy message
    always_comb begin
        w_realtime = (rx_data[7:3] == 5'b11111);
        w_accept   = rx_valid && !w_busy && !w_realtime;
        w_is_data  = !rx_data[7];
        w_is_chan  = rx_data[7] && (rx_data[7:4] != 4'hF);
        w_is_sys   = (rx_data[7:4] == 4'hF) && !w_realtime;
        // 0xCn / 0xDn carry a single data byte
        w_one_byte = (r_stat_hi[2:1] == 2'b10);
        w_complete = w_accept && w_is_data && r_stat_vld && (w_one_byte || r_cnt);
        w_trigger  = w_complete &&
                     ((r_stat_hi == 4'h8) || (r_stat_hi == 4'h9) || (r_stat_hi == 4'hA));
        w_new_type = EV_OFF;
        if (r_stat_hi == 4'hA) begin
            w_new_type = EV_KP;
        end else if ((r_stat_hi == 4'h9) && (rx_data[6:0] != 7'd0)) begin
            w_new_type = EV_ON;
        end
    end

    // Inspect the current slot and fold it into the running match/free results
    always_comb begin
        w_slot_vld      = r_vvld[r_scan_idx];
        w_hit           = w_slot_vld && (r_vnote[r_scan_idx] == r_ev_note) &&
                          (r_vch[r_scan_idx] == r_ev_ch);
        w_fin_match_vld = r_match_vld || w_hit;
        w_fin_match_idx = r_match_vld ? r_match_idx : r_scan_idx;
        w_fin_free_vld  = r_free_vld || !w_slot_vld;
        w_fin_free_idx  = r_free_vld ? r_free_idx : r_scan_idx;
        w_scan_done     = (r_state == S_SCAN) && (r_scan_idx == LAST_IDX);
    end

    // Final allocation decision, taken on the last scan cycle
    always_comb begin
        w_emit_p    = 1'b0;
        w_emit_r    = 1'b0;
        w_emit_k    = 1'b0;
        w_emit_idx  = w_fin_match_idx;
        w_steal_adv = 1'b0;
        case (r_ev_type)
            EV_ON: begin
                w_emit_p = 1'b1;
                if (w_fin_match_vld) begin
                    w_emit_idx = w_fin_match_idx;
                end else if (w_fin_free_vld) begin
                    w_emit_idx = w_fin_free_idx;
                end else begin
                    w_emit_idx  = r_steal;
                    w_steal_adv = 1'b1;
                end
            end
            EV_OFF:  w_emit_r = w_fin_match_vld;
            EV_KP:   w_emit_k = w_fin_match_vld;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk32) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; busy covers both the scan and the emit cycle
    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_trigger) w_next = S_SCAN;
            end
            S_SCAN:  if (r_scan_idx == LAST_IDX) w_next = S_EMIT;
            S_EMIT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = w_busy;

    // Running status, data byte counter and the sticky overrun flag
    always_ff @(posedge clk32) begin
        if (rst) begin
            r_stat_vld <= 1'b0;
            r_stat_hi  <= 4'h0;
            r_stat_ch  <= 4'h0;
            r_cnt      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_valid && w_busy && !w_realtime) overrun <= 1'b1;
            if (w_accept) begin
                if (w_is_chan) begin
                    r_stat_vld <= 1'b1;
                    r_stat_hi  <= rx_data[7:4];
                    r_stat_ch  <= rx_data[3:0];
                    r_cnt      <= 1'b0;
                end else if (w_is_sys) begin
                    r_stat_vld <= 1'b0;
                    r_cnt      <= 1'b0;
                end else if (w_is_data && r_stat_vld) begin
                    r_cnt <= w_complete ? 1'b0 : 1'b1;
                end
            end
        end
    end

    // Key and event payload capture (pure data, no reset needed)
    always_ff @(posedge clk32) begin
        if (w_accept && w_is_data && r_stat_vld && !r_cnt) r_key <= rx_data[6:0];
        if (w_trigger) begin
            r_ev_type <= w_new_type;
            r_ev_note <= r_key;
            r_ev_vel  <= rx_data[6:0];
            r_ev_ch   <= r_stat_ch;
        end
    end

    // Slot scan: walk one slot per cycle, remember first match and lowest free
    always_ff @(posedge clk32) begin
        if (rst) begin
            r_scan_idx  <= '0;
            r_match_vld <= 1'b0;
            r_match_idx <= '0;
            r_free_vld  <= 1'b0;
            r_free_idx  <= '0;
        end else if (r_state == S_IDLE) begin
            r_scan_idx  <= '0;
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
        end else if (r_state == S_SCAN) begin
            r_scan_idx  <= w_scan_done ? '0 : r_scan_idx + 1'b1;
            r_match_vld <= w_fin_match_vld;
            r_match_idx <= w_fin_match_idx;
            r_free_vld  <= w_fin_free_vld;
            r_free_idx  <= w_fin_free_idx;
        end
    end

    // Registered emit: strobes, event outputs, slot valid bits and steal pointer
    always_ff @(posedge clk32) begin
        if (rst) begin
            note_pressed  <= 1'b0;
            note_released <= 1'b0;
            note_keypress <= 1'b0;
            note          <= 7'd0;
            velocity      <= 7'd0;
            channel       <= 4'd0;
            addr          <= 8'd0;
            r_steal       <= '0;
            r_vvld        <= '0;
        end else begin
            note_pressed  <= w_scan_done && w_emit_p;
            note_released <= w_scan_done && w_emit_r;
            note_keypress <= w_scan_done && w_emit_k;
            if (w_scan_done && (w_emit_p || w_emit_r || w_emit_k)) begin
                note     <= r_ev_note;
                velocity <= r_ev_vel;
                channel  <= r_ev_ch;
                addr     <= 8'(w_emit_idx);
            end
            if (w_scan_done && w_emit_p) r_vvld[w_emit_idx] <= 1'b1;
            if (w_scan_done && w_emit_r) r_vvld[w_emit_idx] <= 1'b0;
            if (w_scan_done && w_steal_adv) begin
                r_steal <= (r_steal == LAST_IDX) ? '0 : r_steal + 1'b1;
            end
        end
    end

    // Voice table note/channel storage, written when a voice is started
    always_ff @(posedge clk32) begin
        if (w_scan_done && w_emit_p) begin
            r_vnote[w_emit_idx] <= r_ev_note;
            r_vch[w_emit_idx]   <= r_ev_ch;
        end
    end

endmodule
